serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial binary subtractor: computes diff = a - b - bin one bit per clock, LSB first,
//  through a single full-subtractor cell and a registered borrow. It is the subtract-side
//  counterpart of the team's full-adder datapath. It serves area-constrained arithmetic
//  paths where WIDTH-cycle latency is acceptable; it sits behind a start/done handshake.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk    in   1      clock; all state updates on rising edge
//  rst    in   1      synchronous reset, active-high
//  start  in   1      request; sampled only when busy==0
//  a      in   WIDTH  minuend, captured on accepted start
//  b      in   WIDTH  subtrahend, captured on accepted start
//  bin    in   1      borrow-in, captured on accepted start
//  busy   out  1      1 while a subtraction is in progress (state SHIFT)
//  done   out  1      one-cycle pulse: diff/bout valid this cycle
//  diff   out  WIDTH  result a-b-bin mod 2^WIDTH; held until next accepted start
//  bout   out  1      final borrow: 1 iff a < b+bin (unsigned)
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, diff=0, bout=0, internal regs/counter=0.
//  - Reset is synchronous and wins over everything, including mid-operation: the
//    operation is discarded, with no done pulse.
//  - FSM: IDLE -> SHIFT on start; SHIFT -> DONE after WIDTH bit-cycles; DONE -> IDLE,
//    or DONE -> SHIFT if start is high in DONE.
//  - Accept: start==1 && state in {IDLE,DONE}. On accept: load a_sh=a, b_sh=b,
//    borrow=bin, cnt=0; clear diff; bout=0. start while busy is ignored (no queueing).
//  - SHIFT cycle k (k=0..WIDTH-1): d=a_sh[0]^b_sh[0]^borrow;
//    nb=(~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow).
//    diff shifts right with d entering at MSB; a_sh, b_sh shift right; borrow<=nb; cnt++.
//  - After the WIDTH-th SHIFT cycle: diff holds the full result and bout<=final borrow.
//    The FSM moves to DONE; done=1 for exactly that one cycle.
//  - Latency: start accepted at edge N -> done high during cycle after edge N+WIDTH+... ;
//    precisely, done asserts WIDTH+1 cycles after the start cycle.
//  - Throughput: back-to-back start in the DONE cycle gives one result per WIDTH+1 cycles.
//  - busy=1 exactly in SHIFT; done=1 exactly in DONE; both 0 in IDLE.
//  - cnt width $clog2(WIDTH)+1; terminal compare cnt==WIDTH-1. No wrap beyond that.
//  - Inputs a/b/bin may change freely while busy; only captured values are used.
//  - diff/bout are stable from done until the next accepted start.
// STRUCTURE
//  - Package serial_arith_pkg: typedef enum logic [1:0] {IDLE,SHIFT,DONE} ser_state_t.
//    It is shared with a future serial adder.
//  - Sub-module full_subtractor (a, b, bin -> diff, bout), purely combinational;
//    instantiated once as the bit cell.
//  - Top: FSM, counter, two operand shift registers, result shift register, borrow flop.
// TESTING (WIDTH=8; each check uses an immediate assertion at done)
//  1. a=8'd5, b=8'd3, bin=0 -> done 9 cycles after start; diff=8'd2, bout=0.
//  2. a=8'd3, b=8'd5, bin=0 -> diff=8'hFE, bout=1.
//  3. a=0, b=0, bin=1 -> diff=8'hFF, bout=1; a=8'hFF, b=8'hFF, bin=0 -> diff=0, bout=0.
//  4. Start, pulse start again at cycle 3 with other operands -> ignored.
//     First result only; then start in the DONE cycle -> second result 9 cycles later.
//  5. rst=1 at cycle 4 of SHIFT -> next cycle busy=0, done=0, diff=0, bout=0.
//     No done pulse; a fresh start then completes correctly.
//  6. 200 random {a,b,bin} via $urandom -> {bout,diff} == {1'b0,a}-{1'b0,b}-bin every time.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic blocks (subtractor now, adder later).
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  always_comb begin
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock,
// behind a start/done handshake.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  ser_state_t        state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_q, borrow_d;
  logic              bout_q, bout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cell_diff;
  logic              cell_bout;

  full_subtractor u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = SHIFT;
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          diff_d   = '0;
          bout_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Result enters at the MSB so after WIDTH shifts bit 0 holds the LSB.
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        diff_d   = {cell_diff, diff_q[WIDTH-1:1]};
        borrow_d = cell_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = DONE;
          bout_d  = cell_bout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
    diff = diff_q;
    bout = bout_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): stimulus pushes expected
// results, a negedge monitor pops and checks them whenever done is high.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got diff=%h bout=%b with no pending request", diff, bout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert ({bout, diff} == {e.bout, e.diff})
        else begin
          failures++;
          $display("FAIL result: got bout=%b diff=%h, expected bout=%b diff=%h",
                   bout, diff, e.bout, e.diff);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL latency: done at cycle %0d, expected cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic check1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic check_idle_zero(input string name);
    check1({name, "_busy"}, busy, 1'b0);
    check1({name, "_done"}, done, 1'b0);
    check1({name, "_bout"}, bout, 1'b0);
    checks++;
    if (diff !== '0) begin
      failures++;
      $display("FAIL %s_diff: got %h, expected 00", name, diff);
    end
  endtask

  // Called right after a negedge; start is accepted at the next posedge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       input logic [W-1:0] ediff, input logic ebout);
    exp_t e;
    start = 1'b1;
    a     = ia;
    b     = ib;
    bin   = ibin;
    e.diff = ediff;
    e.bout = ebout;
    e.cyc  = cyc + 9;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs while busy: only captured values may matter.
    a   = W'($urandom);
    b   = W'($urandom);
    bin = 1'($urandom);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done within 20 cycles, expected done", name);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    issue(8'd5, 8'd3, 1'b0, 8'd2, 1'b0);
    wait_done("t1");
    @(negedge clk);
    check1("idle_after_done", done, 1'b0);
    issue(8'd3, 8'd5, 1'b0, 8'hFE, 1'b1);
    wait_done("t2");
    @(negedge clk);
    issue(8'd0, 8'd0, 1'b1, 8'hFF, 1'b1);
    wait_done("t3a");
    @(negedge clk);
    issue(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
    wait_done("t3b");
    @(negedge clk);

    // Start while busy is ignored; then back-to-back start in DONE
    issue(8'h64, 8'h20, 1'b0, 8'h44, 1'b0);
    repeat (2) @(negedge clk);
    check1("busy_mid", busy, 1'b1);
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h02;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4a");
    issue(8'h10, 8'h11, 1'b1, 8'hFE, 1'b1);
    wait_done("t4b");
    @(negedge clk);

    // Reset mid-operation discards the result
    issue(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check_idle_zero("mid_reset");
    repeat (12) @(negedge clk);
    issue(8'h80, 8'h01, 1'b1, 8'h7E, 1'b0);
    wait_done("t5");
    @(negedge clk);

    // Random operands against a 9-bit reference
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb;
      logic         rbin;
      logic [W:0]   ref9;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      issue(ra, rb, rbin, ref9[W-1:0], ref9[W]);
      wait_done("rand");
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending: got %0d outstanding results, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
